// File: rtl/tile_pkg.sv
// Shared encodings for the tile edge-function evaluator and its scan sequencer.
// Command codes are consumed by the tile; the state enum is private to tile_scan.
package tile_pkg;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_RESTART = 2'd1;
  localparam logic [1:0] CMD_STEPY   = 2'd2;
  localparam logic [1:0] CMD_STEPX   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    SCAN    = 2'd2
  } scan_state_t;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_scan.sv
// Raster sequencer driving a tile's restart/stepy/stepx commands; first pixel 2 cycles after start.
// Pixel stream is valid/ready; a stalled pixel freezes the tile (command=nop) so outputs hold.
module tile_scan
  import tile_pkg::*;
#(
  parameter int TILE_W     = 32,
  parameter int TILE_H     = 32,
  parameter int XW         = 11,
  parameter int YW         = 11,
  parameter int SKIP_EMPTY = 0,
  parameter int CW         = $clog2(TILE_W*TILE_H+1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] origin_x,
  input  logic [YW-1:0] origin_y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] covered_count,
  output logic [1:0]    command,
  input  logic          inside_triangle,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          pixel_inside
);

  localparam int XCW = cnt_w(TILE_W);
  localparam int YCW = cnt_w(TILE_H);
  localparam logic [XCW-1:0] X_LAST = XCW'(TILE_W-1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(TILE_H-1);

  scan_state_t    r_state, w_state_nxt;
  logic [XCW-1:0] r_x, w_x_nxt;
  logic [YCW-1:0] r_y, w_y_nxt;
  logic [XW-1:0]  r_org_x;
  logic [YW-1:0]  r_org_y;
  logic [CW-1:0]  r_cnt;
  logic           r_done;

  logic           w_latch;
  logic           w_valid;
  logic           w_adv;
  logic           w_count;
  logic           w_done_nxt;
  logic [1:0]     w_cmd;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_latch     = 1'b0;
    w_valid     = 1'b0;
    w_adv       = 1'b0;
    w_count     = 1'b0;
    w_done_nxt  = 1'b0;
    w_cmd       = CMD_NOP;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_latch     = 1'b1;
          w_state_nxt = RESTART;
        end
      end
      RESTART: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_cmd       = CMD_RESTART;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          // Skipped (uncovered) pixels advance unconditionally; presented ones wait for ready.
          w_valid = !((SKIP_EMPTY != 0) && !inside_triangle);
          w_adv   = w_valid ? pixel_ready : 1'b1;
          if (w_adv) begin
            w_count = inside_triangle;
            if (r_x != X_LAST) begin
              w_cmd   = CMD_STEPX;
              w_x_nxt = r_x + XCW'(1);
            end else if (r_y != Y_LAST) begin
              w_cmd   = CMD_STEPY;
              w_x_nxt = '0;
              w_y_nxt = r_y + YCW'(1);
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_org_x <= '0;
      r_org_y <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_org_x <= origin_x;
        r_org_y <= origin_y;
        r_cnt   <= '0;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_count) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign covered_count = r_cnt;
  assign command       = w_cmd;
  assign pixel_valid   = w_valid;
  assign pixel_x       = r_org_x + XW'(r_x);
  assign pixel_y       = r_org_y + YW'(r_y);
  assign pixel_inside  = (r_state == SCAN) && inside_triangle;

endmodule

// File: tb/tb_tile_scan.sv
// Bench for tile_scan: 4x2 tiles with and without empty-pixel skipping plus a 1x1 tile,
// each loaded by a simple coverage-map tile model, checked against raster-order expectations.
module tb_tile_scan;

  localparam int W = 4;
  localparam int H = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start_c = 1'b0;
  logic        abort = 1'b0;
  logic        pixel_ready = 1'b1;
  logic [10:0] origin_x = '0;
  logic [10:0] origin_y = '0;

  logic        busy_a, done_a, valid_a, pin_a, inside_a;
  logic        busy_b, done_b, valid_b, pin_b, inside_b;
  logic        busy_c, done_c, valid_c, pin_c, inside_c;
  logic [3:0]  cnt_a, cnt_b;
  logic [0:0]  cnt_c;
  logic [1:0]  cmd_a, cmd_b, cmd_c;
  logic [10:0] px_a, py_a, px_b, py_b, px_c, py_c;

  // Tile model: coverage map indexed by the tile's current pixel position.
  logic       cov [W][H];
  logic       cov_c = 1'b0;
  logic [1:0] tx_a = '0, tx_b = '0;
  logic       ty_a = 1'b0, ty_b = 1'b0;

  assign inside_a = cov[tx_a][ty_a];
  assign inside_b = cov[tx_b][ty_b];
  assign inside_c = cov_c;

  always @(posedge clock) begin
    case (cmd_a)
      2'd1: begin tx_a <= '0; ty_a <= 1'b0; end
      2'd2: begin tx_a <= '0; ty_a <= ty_a + 1'b1; end
      2'd3: tx_a <= tx_a + 2'd1;
      default: ;
    endcase
  end

  always @(posedge clock) begin
    case (cmd_b)
      2'd1: begin tx_b <= '0; ty_b <= 1'b0; end
      2'd2: begin tx_b <= '0; ty_b <= ty_b + 1'b1; end
      2'd3: tx_b <= tx_b + 2'd1;
      default: ;
    endcase
  end

  tile_scan #(.TILE_W(W), .TILE_H(H), .XW(11), .YW(11), .SKIP_EMPTY(0), .CW(4)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .origin_x(origin_x), .origin_y(origin_y), .busy(busy_a), .done(done_a),
    .covered_count(cnt_a), .command(cmd_a), .inside_triangle(inside_a),
    .pixel_valid(valid_a), .pixel_ready(pixel_ready), .pixel_x(px_a),
    .pixel_y(py_a), .pixel_inside(pin_a));

  tile_scan #(.TILE_W(W), .TILE_H(H), .XW(11), .YW(11), .SKIP_EMPTY(1), .CW(4)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .origin_x(origin_x), .origin_y(origin_y), .busy(busy_b), .done(done_b),
    .covered_count(cnt_b), .command(cmd_b), .inside_triangle(inside_b),
    .pixel_valid(valid_b), .pixel_ready(pixel_ready), .pixel_x(px_b),
    .pixel_y(py_b), .pixel_inside(pin_b));

  tile_scan #(.TILE_W(1), .TILE_H(1), .XW(11), .YW(11), .SKIP_EMPTY(0), .CW(1)) u_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .abort(abort),
    .origin_x(origin_x), .origin_y(origin_y), .busy(busy_c), .done(done_c),
    .covered_count(cnt_c), .command(cmd_c), .inside_triangle(inside_c),
    .pixel_valid(valid_c), .pixel_ready(pixel_ready), .pixel_x(px_c),
    .pixel_y(py_c), .pixel_inside(pin_c));

  always #5 clock = ~clock;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [22:0] pix [3][64];
  int          cmds [3][64];
  int          npix [3];
  int          ncmd [3];
  int          ndone [3];
  int          done_cyc [3];
  int          mon_err [3];
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [22:0] hold_pix_a, hold_pix_b;

  always @(posedge clock) cyc <= cyc + 1;

  // Observed streams; stall rules: no command while stalled, presented pixel held stable.
  always @(negedge clock) begin
    if (cmd_a != 2'd0 && ncmd[0] < 64) begin cmds[0][ncmd[0]] = int'(cmd_a); ncmd[0]++; end
    if (valid_a && pixel_ready && npix[0] < 64) begin pix[0][npix[0]] = {px_a, py_a, pin_a}; npix[0]++; end
    if (valid_a && !pixel_ready && cmd_a != 2'd0) mon_err[0]++;
    if (hold_a && (!valid_a || {px_a, py_a, pin_a} !== hold_pix_a)) mon_err[0]++;
    hold_a = valid_a && !pixel_ready;
    hold_pix_a = {px_a, py_a, pin_a};
    if (done_a) begin ndone[0]++; done_cyc[0] = cyc; end
  end

  always @(negedge clock) begin
    if (cmd_b != 2'd0 && ncmd[1] < 64) begin cmds[1][ncmd[1]] = int'(cmd_b); ncmd[1]++; end
    if (valid_b && pixel_ready && npix[1] < 64) begin pix[1][npix[1]] = {px_b, py_b, pin_b}; npix[1]++; end
    if (valid_b && !pixel_ready && cmd_b != 2'd0) mon_err[1]++;
    if (hold_b && (!valid_b || {px_b, py_b, pin_b} !== hold_pix_b)) mon_err[1]++;
    hold_b = valid_b && !pixel_ready;
    hold_pix_b = {px_b, py_b, pin_b};
    if (done_b) begin ndone[1]++; done_cyc[1] = cyc; end
  end

  always @(negedge clock) begin
    if (cmd_c != 2'd0 && ncmd[2] < 64) begin cmds[2][ncmd[2]] = int'(cmd_c); ncmd[2]++; end
    if (cmd_c == 2'd2 || cmd_c == 2'd3) mon_err[2]++;
    if (valid_c && pixel_ready && npix[2] < 64) begin pix[2][npix[2]] = {px_c, py_c, pin_c}; npix[2]++; end
    if (done_c) begin ndone[2]++; done_cyc[2] = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 3; d++) begin
      npix[d] = 0; ncmd[d] = 0; ndone[d] = 0; done_cyc[d] = -1; mon_err[d] = 0;
    end
  endtask

  task automatic set_cov(input int randomize_map);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        cov[x][y] = randomize_map != 0 ? 1'($urandom % 2) : (x < 2);
    cov_c = randomize_map != 0 ? 1'($urandom % 2) : 1'b1;
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low 3 cycles on pixel 2 plus a start pulse mid-scan.
  task automatic do_scan(input logic [10:0] ox, input logic [10:0] oy, input int mode);
    logic [22:0] exp_pix [3][64];
    int          exp_n [3];
    int          exp_cmd [8];
    int          exp_cov;
    int          sc;
    logic [63:0] cntv;
    logic [10:0] ex, ey;
    exp_n[0] = 0; exp_n[1] = 0; exp_n[2] = 1; exp_cov = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        ex = ox + 11'(x);
        ey = oy + 11'(y);
        exp_pix[0][exp_n[0]] = {ex, ey, cov[x][y]}; exp_n[0]++;
        if (cov[x][y]) begin exp_pix[1][exp_n[1]] = {ex, ey, 1'b1}; exp_n[1]++; exp_cov++; end
      end
    exp_pix[2][0] = {ox, oy, cov_c};
    exp_cmd[0] = 1;
    for (int i = 1; i < W*H; i++) exp_cmd[i] = (i % W == 0) ? 2 : 3;
    clear_mon();
    origin_x = ox; origin_y = oy; start = 1'b1; start_c = 1'b1;
    pixel_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
    sc = cyc;
    tick();
    start = 1'b0; start_c = 1'b0;
    for (int k = 1; k < 300 && !(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0); k++) begin
      case (mode)
        1: pixel_ready = 1'($urandom % 2);
        2: begin pixel_ready = !(k >= 4 && k <= 6); start = (k == 5); end
        default: pixel_ready = 1'b1;
      endcase
      tick();
    end
    start = 1'b0; pixel_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("npix[%0d] m%0d", d, mode), npix[d], exp_n[d]);
      for (int i = 0; i < exp_n[d] && i < npix[d]; i++)
        check($sformatf("pix[%0d][%0d] m%0d", d, i, mode), pix[d][i], exp_pix[d][i]);
      check($sformatf("ncmd[%0d] m%0d", d, mode), ncmd[d], (d == 2) ? 1 : W*H);
      for (int i = 0; i < ncmd[d] && i < ((d == 2) ? 1 : W*H); i++)
        check($sformatf("cmd[%0d][%0d] m%0d", d, i, mode), cmds[d][i], exp_cmd[i]);
      check($sformatf("stall_rules[%0d] m%0d", d, mode), mon_err[d], 0);
      check($sformatf("ndone[%0d] m%0d", d, mode), ndone[d], 1);
      cntv = (d == 0) ? 64'(cnt_a) : (d == 1) ? 64'(cnt_b) : 64'(cnt_c);
      check($sformatf("covered[%0d] m%0d", d, mode), cntv, (d == 2) ? 64'(cov_c) : 64'(exp_cov));
      if (mode == 0)
        check($sformatf("done_lat[%0d]", d), done_cyc[d] - sc, (d == 2) ? 3 : W*H + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cov(0);
    clear_mon();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst busy", busy_a, 1'b0);
    check("rst done", done_a, 1'b0);
    check("rst command", cmd_a, 2'd0);
    check("rst valid", valid_a, 1'b0);
    check("rst covered", cnt_a, 4'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();

    // Directed scan, ready held high.
    do_scan(11'd100, 11'd50, 0);
    // Stall on (102,50) and a start pulse during SCAN.
    do_scan(11'd100, 11'd50, 2);

    // Abort while presenting (101,51).
    clear_mon();
    origin_x = 11'd100; origin_y = 11'd50; start = 1'b1; start_c = 1'b1;
    tick();
    start = 1'b0; start_c = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    @(negedge clock);
    check("abort px", px_a, 11'd101);
    check("abort py", py_a, 11'd51);
    check("abort cmd", cmd_a, 2'd0);
    check("abort valid", valid_a, 1'b0);
    @(posedge clock); #1 abort = 1'b0;
    check("abort busy_a", busy_a, 1'b0);
    check("abort busy_b", busy_b, 1'b0);
    check("abort covered_a", cnt_a, 4'd3);
    check("abort covered_b", cnt_b, 4'd3);
    repeat (3) tick();
    check("abort no done_a", ndone[0], 0);
    check("abort no done_b", ndone[1], 0);

    // start and abort together in IDLE.
    clear_mon();
    start = 1'b1; start_c = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; start_c = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start+abort busy", busy_a, 1'b0);
    tick();
    check("start+abort no cmd", ncmd[0], 0);

    // Asynchronous reset mid-scan.
    clear_mon();
    origin_x = 11'd7; origin_y = 11'd9; start = 1'b1; start_c = 1'b1;
    tick();
    start = 1'b0; start_c = 1'b0;
    repeat (4) tick();
    #3 reset_n = 1'b0;
    #1;
    check("arst busy", busy_a, 1'b0);
    check("arst valid", valid_a, 1'b0);
    check("arst cmd", cmd_a, 2'd0);
    check("arst covered", cnt_a, 4'd0);
    check("arst done", done_a, 1'b0);
    @(posedge clock); #1 reset_n = 1'b1;
    tick();
    do_scan(11'd300, 11'd400, 0);

    // Randomized coverage, origins (including wrap) and backpressure.
    for (int r = 0; r < 6; r++) begin
      set_cov(1);
      do_scan((r % 2 == 0) ? 11'($urandom_range(2040, 2047)) : 11'($urandom),
              (r % 3 == 0) ? 11'($urandom_range(2046, 2047)) : 11'($urandom), 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_scan.md
Name: tile_scan

Overview:
- Sequencer on the driving end of the tile edge-function evaluator.
- Issues the tile's restart/stepy/stepx command stream in raster order over a TILE_W x TILE_H tile.
- Samples the tile's inside_triangle flag at each pixel and emits a pixel stream (screen coordinates plus coverage) under valid/ready backpressure.
- Sits between the triangle setup stage, which loads the tile's a/b/c coefficients and pulses start, and the pixel/fragment consumer.

Parameters:
- TILE_W, 32, pixels per tile row (>=1)
- TILE_H, 32, rows per tile (>=1)
- XW, 11, screen x coordinate width
- YW, 11, screen y coordinate width
- SKIP_EMPTY, 0, 1 = uncovered pixels are consumed internally and never presented downstream
- CW, $clog2(TILE_W*TILE_H+1), covered-pixel counter width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin scan of one tile; honoured only in IDLE
- abort  in  1  terminate any scan in progress
- origin_x  in  XW  tile origin x, latched on accepted start
- origin_y  in  YW  tile origin y, latched on accepted start
- busy  out  1  high in RESTART and SCAN
- done  out  1  one-cycle pulse after the last pixel is consumed
- covered_count  out  CW  covered pixels in the current/last tile
- command  out  2  to tile: 0 nop, 1 restart, 2 stepy, 3 stepx
- inside_triangle  in  1  from tile; combinational function of the tile's current e
- pixel_valid  out  1  pixel presented
- pixel_ready  in  1  consumer accepts pixel
- pixel_x  out  XW  origin_x + x (mod 2^XW)
- pixel_y  out  YW  origin_y + y (mod 2^YW)
- pixel_inside  out  1  coverage of presented pixel

Behaviour:
- Reset: state=IDLE, x=y=0, origin regs=0, covered_count=0, done=0, busy=0, command=0, pixel_valid=0.
- IDLE: command=0.
  - start=1 and abort=0 -> latch origins, clear covered_count, go to RESTART.
- RESTART: exactly one cycle, command=1. Then go to SCAN with x=y=0.
- SCAN: the tile's e holds pixel (x,y) on the cycle SCAN is entered and after every step.
  - pixel_inside = inside_triangle (combinational).
  - pixel_valid = !(SKIP_EMPTY && !inside_triangle).
  - adv = pixel_valid ? pixel_ready : 1.
  - command is combinational:
    - adv=0 -> 0.
    - adv=1 and x<TILE_W-1 -> 3 (stepx); x++.
    - adv=1, x==TILE_W-1, y<TILE_H-1 -> 2 (stepy); x=0, y++.
    - adv=1 at the last pixel -> 0; go to IDLE; done=1 next cycle.
  - covered_count increments on each adv cycle with inside_triangle=1.
- Exactly one command is issued per consumed pixel. The tile is never stepped while a presented pixel is stalled.
- Latency: start to first pixel_valid = 2 cycles. Full tile with ready held high = TILE_W*TILE_H+1 cycles from RESTART to done.
- pixel_x/pixel_y/pixel_inside are stable while pixel_valid=1 and pixel_ready=0 (the tile is not stepped).
- abort=1 has priority in every state:
  - that cycle: command=0, pixel_valid=0, no count increment;
  - next state IDLE, no done pulse; covered_count holds its partial value.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- TILE_W=1: never issues stepx. TILE_H=1: never issues stepy.
- Coordinate addition wraps modulo 2^XW / 2^YW; no saturation.
- Async reset mid-scan: immediate return to reset values. The tile's e is stale until the next RESTART.

Decomposition:
- Shared package (tile_pkg):
  - command encoding constants CMD_NOP=0, CMD_RESTART=1, CMD_STEPY=2, CMD_STEPX=3 (also used by tile);
  - state enum IDLE/RESTART/SCAN.
- No sub-module needed. The x/y raster counter is a small always block. The bench instantiates tile as the load.

Test Plan:
- Tile loaded with edge0 c=1,a=-1,b=0, edges1/2 all 0; TILE_W=4, TILE_H=2, origin (100,50), ready=1:
  - command sequence 1,3,3,3,2,3,3,3,0;
  - pixels (100..103,50),(100..103,51) with inside 1,1,0,0 per row;
  - done 10 cycles after start; covered_count=4.
- Same setup, SKIP_EMPTY=1:
  - only 4 pixels presented: x=100,101 on each row;
  - done 10 cycles after start; covered_count=4.
- ready low for 3 cycles on pixel (102,50):
  - command=0 throughout the stall;
  - pixel_x/y/inside held stable;
  - scan resumes with stepx.
- abort asserted while presenting pixel (101,51):
  - command=0 that cycle; IDLE next cycle; no done;
  - busy=0; covered_count=3.
- start pulsed during SCAN -> ignored, no RESTART issued. start with abort together in IDLE -> stays IDLE.
- reset_n low mid-scan (asynchronous, between clock edges):
  - outputs go to reset values immediately;
  - after release, a new start gives a clean restart and a full pixel sequence.
